// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 valid/ready stream multiplexer with a registered
// output stage. The channel is picked either by a fixed select index or by a
// round-robin search that starts just after the most recently granted channel.
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // Output register and arbitration state
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_chan_q,  out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  last_grant_q, last_grant_d;

  // Combinational arbitration signals
  logic             load_en;
  logic [SELW-1:0]  grant_rr;
  logic             found_rr;
  logic [SELW-1:0]  grant;
  logic             grant_ok;
  logic             grant_valid;
  logic             accept;
  logic [WIDTH-1:0] chan_data [NCH];

  // Unpack the flat data bus into one word per channel
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // The register can take a new beat when it is empty or being drained
  assign load_en = !out_valid_q || out_ready;

  // Round-robin search: last_grant+1, +2, ... wrapping modulo NCH
  always_comb begin
    int idx;
    idx      = 0;
    grant_rr = '0;
    found_rr = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      idx = int'(last_grant_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!found_rr && in_valid[idx]) begin
        found_rr = 1'b1;
        grant_rr = SELW'(idx);
      end
    end
  end

  // Select the grant source by mode; an out-of-range sel grants nothing
  always_comb begin
    if (mode) begin
      grant    = grant_rr;
      grant_ok = found_rr;
    end else begin
      grant    = sel;
      grant_ok = (int'(sel) < NCH);
    end
  end

  // in_ready is one-hot at the granted channel, and forced low during reset
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
      assign in_ready[gi] = !rst && grant_ok && load_en && (grant == SELW'(gi));
    end
  endgenerate

  assign grant_valid = grant_ok && in_valid[grant];
  assign accept      = grant_valid && load_en;

  // Next-state: accept replaces the buffered beat, drain clears valid, stall holds
  always_comb begin
    out_data_d   = out_data_q;
    out_chan_d   = out_chan_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      out_data_d  = chan_data[grant];
      out_chan_d  = grant;
      out_valid_d = 1'b1;
      if (mode) last_grant_d = grant;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; last_grant resets to NCH-1 so the first RR grant is ch0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q   <= '0;
      out_chan_q   <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= SELW'(NCH - 1);
    end else begin
      out_data_q   <= out_data_d;
      out_chan_q   <= out_chan_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule
